// File: rtl/ca4_frame_ctrl.sv
// Framed serial loader for a ROWS x COLS matrix: start bit, row-major data, stop bit, valid/ready hand-off.
// Optional even-parity field between data and stop is compiled in with `define CA4_PARITY_EN.
module ca4_frame_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 5
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          serIn,
    output logic [0:ROWS-1][0:COLS-1]     L,
    output logic                          lValid,
    input  logic                          lReady,
    output logic                          busy,
    output logic                          frameErr,
    output logic                          overrun
);

    localparam int NBITS = ROWS * COLS;
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

`ifdef CA4_PARITY_EN
    // Even parity over data plus the received parity bit must reduce to zero.
    function automatic logic parity_ok(input logic [0:NBITS-1] data, input logic pbit);
        return ~((^data) ^ pbit);
    endfunction
`endif

    state_t                       state_r, state_nxt_s;
    logic                         armed_r, armed_nxt_s;
    logic [CNT_W-1:0]             count_r, count_nxt_s;
    logic [0:NBITS-1]             shadow_r, shadow_nxt_s;
    logic [0:ROWS-1][0:COLS-1]    l_r, l_nxt_s;
    logic                         lvalid_r, lvalid_nxt_s;
    logic                         ferr_r, ferr_nxt_s;
    logic                         overrun_r, overrun_nxt_s;

    // Next-state and datapath decode for the framing sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        armed_nxt_s   = armed_r;
        count_nxt_s   = count_r;
        shadow_nxt_s  = shadow_r;
        l_nxt_s       = l_r;
        lvalid_nxt_s  = lvalid_r;
        ferr_nxt_s    = 1'b0;
        overrun_nxt_s = overrun_r;

        case (state_r)
            ST_IDLE: begin
                // A start bit only counts once the line has been seen idle-high.
                if (serIn) begin
                    armed_nxt_s = 1'b1;
                end else if (armed_r) begin
                    state_nxt_s = ST_DATA;
                    count_nxt_s = {CNT_W{1'b0}};
                end else begin
                    armed_nxt_s = 1'b0;
                end
            end
            ST_DATA: begin
                shadow_nxt_s[count_r[IDX_W-1:0]] = serIn;
                count_nxt_s = count_r + CNT_W'(1);
                if (count_r == LAST_CNT) begin
`ifdef CA4_PARITY_EN
                    state_nxt_s = ST_PARITY;
`else
                    state_nxt_s = ST_STOP;
`endif
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
`ifdef CA4_PARITY_EN
                if (parity_ok(shadow_r, serIn)) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    ferr_nxt_s  = 1'b1;
                    armed_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
`else
                armed_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (serIn) begin
                    l_nxt_s      = shadow_r;
                    lvalid_nxt_s = 1'b1;
                    state_nxt_s  = ST_HOLD;
                end else begin
                    ferr_nxt_s  = 1'b1;
                    armed_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Bits arriving while the consumer stalls are dropped, not shifted.
                if (lReady) begin
                    lvalid_nxt_s = 1'b0;
                    armed_nxt_s  = 1'b0;
                    state_nxt_s  = ST_IDLE;
                end else if (!serIn) begin
                    overrun_nxt_s = 1'b1;
                end else begin
                    overrun_nxt_s = overrun_r;
                end
            end
            default: begin
                armed_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            armed_r   <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            shadow_r  <= {NBITS{1'b0}};
            l_r       <= {NBITS{1'b0}};
            lvalid_r  <= 1'b0;
            ferr_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            armed_r   <= armed_nxt_s;
            count_r   <= count_nxt_s;
            shadow_r  <= shadow_nxt_s;
            l_r       <= l_nxt_s;
            lvalid_r  <= lvalid_nxt_s;
            ferr_r    <= ferr_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign L        = l_r;
    assign lValid   = lvalid_r;
    assign frameErr = ferr_r;
    assign overrun  = overrun_r;
    assign busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ca4_frame_ctrl.sv
// Directed self-checking bench for ca4_frame_ctrl (also exercises the CA4_PARITY_EN build).
module tb_ca4_frame_ctrl;

    logic                 CLK;
    logic                 RST;
    logic                 serIn;
    logic [0:3][0:3]      L;
    logic                 lValid;
    logic                 lReady;
    logic                 busy;
    logic                 frameErr;
    logic                 overrun;

    int errors;
    int checks;

    localparam logic [15:0] D1 = 16'b1011_0011_1110_0101;
    localparam logic [15:0] D2 = 16'b0110_1001_0000_1111;

    ca4_frame_ctrl #(.ROWS(4), .COLS(4), .CNT_W(5)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .serIn    (serIn),
        .L        (L),
        .lValid   (lValid),
        .lReady   (lReady),
        .busy     (busy),
        .frameErr (frameErr),
        .overrun  (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serIn = b;
        @(posedge CLK);
        #1;
    endtask

    // Start bit plus 16 data bits, first bit sent is D[15] -> L[0][0].
    task automatic send_body(input logic [15:0] d);
        send_bit(1'b0);
        chk("start_busy", 32'(busy), 32'd1);
        for (int i = 15; i >= 0; i--) begin
            send_bit(d[i]);
        end
    endtask

    task automatic send_parity(input logic [15:0] d);
`ifdef CA4_PARITY_EN
        send_bit(^d);
`else
        serIn = 1'b1;
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST    = 1'b0;
        serIn  = 1'b0;
        lReady = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_L", 32'(L), 32'd0);
        chk("rst_lValid", 32'(lValid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frameErr", 32'(frameErr), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Line stuck low after reset must not start a frame.
        RST = 1'b1;
        repeat (4) send_bit(1'b0);
        chk("stuck_low_busy", 32'(busy), 32'd0);
        send_bit(1'b1);
        chk("armed_idle_busy", 32'(busy), 32'd0);

        // Bad stop bit.
        send_body(D1);
        send_parity(D1);
        chk("pre_stop_lvalid", 32'(lValid), 32'd0);
        send_bit(1'b0);
        chk("badstop_frameErr", 32'(frameErr), 32'd1);
        chk("badstop_lValid", 32'(lValid), 32'd0);
        chk("badstop_L", 32'(L), 32'd0);
        chk("badstop_busy", 32'(busy), 32'd0);
        send_bit(1'b1);
        chk("badstop_pulse_end", 32'(frameErr), 32'd0);
        send_bit(1'b1);

        // Good frame.
        send_body(D1);
        send_parity(D1);
        chk("good_pre_stop_lvalid", 32'(lValid), 32'd0);
        send_bit(1'b1);
        chk("good_lValid", 32'(lValid), 32'd1);
        chk("good_L", 32'(L), 32'(D1));
        chk("good_row0", 32'(L[0]), 32'h0000000b);
        chk("good_row1", 32'(L[1]), 32'h00000003);
        chk("good_row2", 32'(L[2]), 32'h0000000e);
        chk("good_row3", 32'(L[3]), 32'h00000005);
        chk("good_frameErr", 32'(frameErr), 32'd0);
        chk("good_overrun", 32'(overrun), 32'd0);

        // Handshake hold then accept.
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            chk("hold_lValid", 32'(lValid), 32'd1);
            chk("hold_L", 32'(L), 32'(D1));
            chk("hold_busy", 32'(busy), 32'd1);
        end
        lReady = 1'b1;
        send_bit(1'b1);
        lReady = 1'b0;
        chk("accept_lValid", 32'(lValid), 32'd0);
        chk("accept_busy", 32'(busy), 32'd0);
        chk("accept_L_kept", 32'(L), 32'(D1));

        // Overrun while holding an unaccepted frame.
        send_bit(1'b1);
        send_body(D2);
        send_parity(D2);
        send_bit(1'b1);
        chk("f2_L", 32'(L), 32'(D2));
        chk("f2_lValid", 32'(lValid), 32'd1);
        chk("f2_overrun_clear", 32'(overrun), 32'd0);
        repeat (3) send_bit(1'b0);
        chk("ovr_overrun", 32'(overrun), 32'd1);
        chk("ovr_lValid", 32'(lValid), 32'd1);
        chk("ovr_L", 32'(L), 32'(D2));
        lReady = 1'b1;
        send_bit(1'b1);
        lReady = 1'b0;
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_accept_lValid", 32'(lValid), 32'd0);
        chk("ovr_accept_L", 32'(L), 32'(D2));

        // Asynchronous reset in the middle of the data field.
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 15; i > 8; i--) begin
            send_bit(D1[i]);
        end
        chk("midframe_busy", 32'(busy), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("async_L", 32'(L), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_lValid", 32'(lValid), 32'd0);
        chk("async_overrun", 32'(overrun), 32'd0);
        #2;
        RST   = 1'b1;
        serIn = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef CA4_PARITY_EN
        // Wrong parity: error pulse, nothing committed.
        send_body(D1);
        send_bit(~(^D1));
        chk("par_frameErr", 32'(frameErr), 32'd1);
        chk("par_lValid", 32'(lValid), 32'd0);
        chk("par_L", 32'(L), 32'd0);
        chk("par_busy", 32'(busy), 32'd0);
        send_bit(1'b1);
        chk("par_pulse_end", 32'(frameErr), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ca4_frame_ctrl.md
Name: ca4_frame_ctrl

Overview:
- Sequencing controller for the serial 4x4 matrix loader: frames the raw `serIn` bit stream into start / data / stop fields.
- Shifts 16 data bits into a shadow matrix and commits it to `L` only on a good frame.
- Hands the committed matrix downstream with a valid/ready handshake.
- Sits between the serial input pin and the matrix-consuming logic. It replaces free-running shifting with framed, error-checked loads.

Parameters:
- ROWS, 4, matrix row count.
- COLS, 4, matrix column count; data bits per frame = ROWS*COLS.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > ROWS*COLS.

Ports:
- CLK  in  1  clock; all sampling on rising edge.
- RST  in  1  reset; asynchronous, active-low.
- serIn  in  1  serial line, idle-high, one bit per CLK.
- L  out  [0:ROWS-1][0:COLS-1]  last committed matrix.
- lValid  out  1  `L` holds a new frame not yet accepted.
- lReady  in  1  consumer accepts `L` when high with `lValid`.
- busy  out  1  high in every state except IDLE.
- frameErr  out  1  one-cycle pulse on bad stop bit (or bad parity, see option).
- overrun  out  1  sticky; a start bit arrived while in HOLD.

Behaviour:
- Reset (RST=0, async): state=IDLE, armed=0, count=0, shadow=0, L=0, lValid=0, frameErr=0, overrun=0.
- States: IDLE, DATA, [PARITY], STOP, HOLD.
- IDLE:
  - Sampled `serIn`=1 sets armed=1.
  - Sampled `serIn`=0 with armed=1 is the start bit: go to DATA, count=0.
  - Sampled `serIn`=0 with armed=0 is ignored. A line stuck low after reset never starts a frame.
- DATA:
  - Each edge writes `serIn` into shadow[count/COLS][count%COLS], then count++. Order is row-major; the first data bit lands in L[0][0].
  - After bit ROWS*COLS-1: go to STOP (or PARITY when the option is compiled in).
- STOP, sampled `serIn`=1 (good frame):
  - L<=shadow, lValid<=1, go to HOLD.
  - Latency: `L`/`lValid` change on the stop-bit edge, visible the next cycle.
  - Total 18 edges from start bit to `lValid` high.
- STOP, sampled `serIn`=0 (bad frame):
  - frameErr=1 for exactly one cycle; `L` and `lValid` unchanged.
  - Go to IDLE with armed=0, so the line must return high before the next start.
- HOLD:
  - `lValid` stays high and `L` stays stable until a rising edge with lReady=1.
  - That accept edge clears `lValid`, sets armed=0, and goes to IDLE. `serIn` sampled on the accept edge is ignored.
  - Sampled `serIn`=0 on a non-accept edge sets overrun=1 (sticky until reset). Those bits are dropped, never shifted.
- `lReady` is ignored outside HOLD.
- `busy` = (state != IDLE), decoded combinationally from the state register.
- Reset mid-frame: all state cleared immediately. A partial frame is discarded and `L` returns to 0.
- Count arithmetic: unsigned CNT_W bits; no wrap inside a frame (max value ROWS*COLS-1).

Optional Feature:
- Macro CA4_PARITY_EN.
- Defined:
  - PARITY state after DATA samples one even-parity bit. XOR of the 16 data bits plus the parity bit must be 0.
  - On mismatch: frameErr pulses one cycle, `L` is not committed, and the controller goes to IDLE with armed=0 (the stop bit is not checked).
  - On match: go to STOP. Start-to-`lValid` becomes 19 edges.
- Undefined: no PARITY state; DATA goes directly to STOP.

Test Plan:
- Good frame: reset with `serIn`=1; release; send start 0, data 1011 0011 1110 0101, stop 1 -> after 18 edges lValid=1, L[0]=1011, L[1]=0011, L[2]=1110, L[3]=0101, frameErr=0, overrun=0.
- Handshake hold: same frame, lReady=0 for 5 cycles, then 1 -> `L` stable and lValid=1 throughout; lValid=0 and busy=0 the cycle after the accept edge.
- Bad stop: same data, stop 0 -> frameErr high exactly 1 cycle, lValid=0, L still 0; then `serIn`=1,1 and a repeat frame with a good stop commits normally.
- Overrun: good frame left unaccepted; drive `serIn`=0 for 3 cycles -> overrun=1 stays set after accept; L unchanged.
- Arming and async reset: `serIn`=0 during and after reset -> no start, busy=0. Pulse RST low at data bit 7 of a frame -> L=0 and state IDLE immediately, without waiting for a CLK edge.
- CA4_PARITY_EN: good frame with parity 0 -> committed after 19 edges; same frame with parity 1 -> frameErr pulse, no commit.
